// File: rtl/alu_exec_if.sv
// Bus bundle for the execute-stage ALU/PC block: operands and PC in,
// registered ALU result, flags and next-PC values out.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] pc;
    logic [15:0]      imm16;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] alu_res;
    logic             zero;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] branch_target;

    modport master (
        output alu_op, a, b, cin, pc, imm16,
        input  alu_ctl, alu_res, zero, cout, ovf, pc_plus1, branch_target
    );

    modport slave (
        input  alu_op, a, b, cin, pc, imm16,
        output alu_ctl, alu_res, zero, cout, ovf, pc_plus1, branch_target
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage datapath: decodes the MIPS funct code into an ALU control
// word, runs the ALU with zero/carry/overflow flags, and forms pc+1 and the
// word-addressed branch target. Every output is registered once.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    alu_exec_if.slave bus
);

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_XOR  = 4'b0011;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_SLTU = 4'b1000;
    localparam logic [3:0] CTL_NOR  = 4'b1100;

    // Funct code to control word; unknown codes fall back to ADD.
    function automatic logic [3:0] decode_op(input logic [5:0] op);
        logic [3:0] ctl;
        case (op)
            6'h20, 6'h21: ctl = CTL_ADD;
            6'h22, 6'h23: ctl = CTL_SUB;
            6'h24:        ctl = CTL_AND;
            6'h25:        ctl = CTL_OR;
            6'h26:        ctl = CTL_XOR;
            6'h27:        ctl = CTL_NOR;
            6'h2A:        ctl = CTL_SLT;
            6'h2B:        ctl = CTL_SLTU;
            default:      ctl = CTL_ADD;
        endcase
        return ctl;
    endfunction

    logic [3:0]       ctl_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] res_s;
    logic             cout_s;
    logic             ovf_s;
    logic [WIDTH-1:0] pc_plus1_s;
    logic [WIDTH-1:0] target_s;
    logic             a_msb_s;
    logic             b_msb_s;

    logic [3:0]       ctl_r;
    logic [WIDTH-1:0] res_r;
    logic             zero_r;
    logic             cout_r;
    logic             ovf_r;
    logic [WIDTH-1:0] pc_plus1_r;
    logic [WIDTH-1:0] target_r;

    // Shared adder/subtractor and PC adders, all one bit wider where carry is needed.
    always_comb begin
        ctl_s      = decode_op(bus.alu_op);
        a_msb_s    = bus.a[WIDTH-1];
        b_msb_s    = bus.b[WIDTH-1];
        add_s      = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        sub_s      = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        pc_plus1_s = bus.pc + {{(WIDTH-1){1'b0}}, 1'b1};
        target_s   = pc_plus1_s + {{(WIDTH-16){bus.imm16[15]}}, bus.imm16};
    end

    // ALU result and flag selection by control word; SLT uses a true signed
    // compare so it stays correct when a-b would overflow.
    always_comb begin
        res_s  = {WIDTH{1'b0}};
        cout_s = 1'b0;
        ovf_s  = 1'b0;
        case (ctl_s)
            CTL_SUB: begin
                res_s  = sub_s[WIDTH-1:0];
                cout_s = sub_s[WIDTH];
                ovf_s  = (a_msb_s != b_msb_s) && (sub_s[WIDTH-1] != a_msb_s);
            end
            CTL_AND:  res_s = bus.a & bus.b;
            CTL_OR:   res_s = bus.a | bus.b;
            CTL_XOR:  res_s = bus.a ^ bus.b;
            CTL_NOR:  res_s = ~(bus.a | bus.b);
            CTL_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            CTL_SLTU: res_s = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: begin
                res_s  = add_s[WIDTH-1:0];
                cout_s = add_s[WIDTH];
                ovf_s  = (a_msb_s == b_msb_s) && (add_s[WIDTH-1] != a_msb_s);
            end
        endcase
    end

    // Output register stage; synchronous reset clears every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_r      <= 4'b0000;
            res_r      <= {WIDTH{1'b0}};
            zero_r     <= 1'b0;
            cout_r     <= 1'b0;
            ovf_r      <= 1'b0;
            pc_plus1_r <= {WIDTH{1'b0}};
            target_r   <= {WIDTH{1'b0}};
        end else begin
            ctl_r      <= ctl_s;
            res_r      <= res_s;
            zero_r     <= (res_s == {WIDTH{1'b0}});
            cout_r     <= cout_s;
            ovf_r      <= ovf_s;
            pc_plus1_r <= pc_plus1_s;
            target_r   <= target_s;
        end
    end

    assign bus.alu_ctl       = ctl_r;
    assign bus.alu_res       = res_r;
    assign bus.zero          = zero_r;
    assign bus.cout          = cout_r;
    assign bus.ovf           = ovf_r;
    assign bus.pc_plus1      = pc_plus1_r;
    assign bus.branch_target = target_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner vectors with
// hand-computed literals plus randomized traffic against an arithmetic model.
module tb_alu_exec_unit;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    alu_exec_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic meaning of each operation.
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [31:0] pc, input logic [15:0] imm,
                         output logic [3:0] ctl, output logic [31:0] res, output logic z,
                         output logic co, output logic ov, output logic [31:0] p1,
                         output logic [31:0] bt);
        longint sa, sb, d;
        logic [63:0] u;
        logic [31:0] sx;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            6'h22, 6'h23: ctl = 4'b0110;
            6'h24: ctl = 4'b0000;
            6'h25: ctl = 4'b0001;
            6'h26: ctl = 4'b0011;
            6'h27: ctl = 4'b1100;
            6'h2A: ctl = 4'b0111;
            6'h2B: ctl = 4'b1000;
            default: ctl = 4'b0010;
        endcase
        co = 1'b0;
        ov = 1'b0;
        case (ctl)
            4'b0110: begin
                res = a - b;
                co  = (a >= b);
                d   = sa - sb;
                ov  = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0011: res = a ^ b;
            4'b1100: res = ~(a | b);
            4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: res = (a < b) ? 32'd1 : 32'd0;
            default: begin
                u   = {32'd0, a} + {32'd0, b} + {63'd0, c};
                res = u[31:0];
                co  = u[32];
                d   = sa + sb + {63'd0, c};
                ov  = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
        endcase
        z  = (res == 32'd0);
        p1 = pc + 32'd1;
        sx = {{16{imm[15]}}, imm};
        bt = pc + 32'd1 + sx;
    endtask

    // Drive one cycle of inputs, clock it in, then compare every output.
    task automatic apply(input logic rst, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic c, input logic [31:0] pc,
                         input logic [15:0] imm);
        logic [3:0] e_ctl;
        logic [31:0] e_res, e_p1, e_bt;
        logic e_z, e_co, e_ov;
        reset = rst;
        bus.alu_op = op; bus.a = a; bus.b = b; bus.cin = c; bus.pc = pc; bus.imm16 = imm;
        model(op, a, b, c, pc, imm, e_ctl, e_res, e_z, e_co, e_ov, e_p1, e_bt);
        if (rst) begin
            e_ctl = 4'd0; e_res = 32'd0; e_z = 1'b0; e_co = 1'b0;
            e_ov = 1'b0; e_p1 = 32'd0; e_bt = 32'd0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("alu_ctl", {28'd0, bus.alu_ctl}, {28'd0, e_ctl});
        chk("alu_res", bus.alu_res, e_res);
        chk("zero", {31'd0, bus.zero}, {31'd0, e_z});
        chk("cout", {31'd0, bus.cout}, {31'd0, e_co});
        chk("ovf", {31'd0, bus.ovf}, {31'd0, e_ov});
        chk("pc_plus1", bus.pc_plus1, e_p1);
        chk("branch_target", bus.branch_target, e_bt);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] r;
        logic [31:0] sel;
        r   = $urandom;
        sel = $urandom_range(0, 7);
        case (sel)
            32'd0:   return 32'h0000_0000;
            32'd1:   return 32'h7FFF_FFFF;
            32'd2:   return 32'h8000_0000;
            32'd3:   return 32'hFFFF_FFFF;
            default: return r;
        endcase
    endfunction

    initial begin
        logic [5:0]  ops [10];
        logic [31:0] r, x, y, p, idx;
        logic        rr;
        vectors = 0;
        miscompares = 0;
        ops = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        reset = 1'b1;
        bus.alu_op = 6'h20; bus.a = 32'd0; bus.b = 32'd0; bus.cin = 1'b0;
        bus.pc = 32'd0; bus.imm16 = 16'd0;

        // Reset held two edges with nonzero inputs
        apply(1'b1, 6'h20, 32'h1234_5678, 32'h1, 1'b1, 32'h40, 16'h5);
        apply(1'b1, 6'h22, 32'h5, 32'h5, 1'b0, 32'h40, 16'h5);
        chk("lit_reset_zero", {31'd0, bus.zero}, 32'd0);
        chk("lit_reset_res", bus.alu_res, 32'd0);

        // ADD overflow and carry
        apply(1'b0, 6'h20, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h10, 16'hFFFE);
        chk("lit_add_ovf_res", bus.alu_res, 32'h8000_0000);
        chk("lit_add_ovf", {31'd0, bus.ovf}, 32'd1);
        chk("lit_pc_plus1", bus.pc_plus1, 32'h11);
        chk("lit_branch_back", bus.branch_target, 32'h0F);
        apply(1'b0, 6'h20, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'hFFFF_FFFF, 16'h0003);
        chk("lit_add_wrap_res", bus.alu_res, 32'd0);
        chk("lit_add_cout", {31'd0, bus.cout}, 32'd1);
        chk("lit_add_zero", {31'd0, bus.zero}, 32'd1);
        chk("lit_add_ctl", {28'd0, bus.alu_ctl}, 32'h2);
        chk("lit_pc_wrap", bus.pc_plus1, 32'd0);
        chk("lit_branch_wrap", bus.branch_target, 32'd3);

        // SUB / SLT / SLTU
        apply(1'b0, 6'h22, 32'd5, 32'd5, 1'b1, 32'h0, 16'h0);
        chk("lit_sub_zero", {31'd0, bus.zero}, 32'd1);
        chk("lit_sub_cout", {31'd0, bus.cout}, 32'd1);
        apply(1'b0, 6'h2A, 32'h8000_0000, 32'd1, 1'b0, 32'h0, 16'h0);
        chk("lit_slt", bus.alu_res, 32'd1);
        apply(1'b0, 6'h2B, 32'h8000_0000, 32'd1, 1'b0, 32'h0, 16'h0);
        chk("lit_sltu", bus.alu_res, 32'd0);

        // Logic ops
        apply(1'b0, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'h0, 16'h0);
        chk("lit_and", bus.alu_res, 32'h00F0_00F0);
        apply(1'b0, 6'h25, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'h0, 16'h0);
        chk("lit_or", bus.alu_res, 32'hFFF0_FFF0);
        apply(1'b0, 6'h26, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'h0, 16'h0);
        chk("lit_xor", bus.alu_res, 32'hFF00_FF00);
        apply(1'b0, 6'h27, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'h0, 16'h0);
        chk("lit_nor", bus.alu_res, 32'h000F_000F);
        chk("lit_nor_cout", {31'd0, bus.cout}, 32'd0);

        // Decode default
        apply(1'b0, 6'h00, 32'd2, 32'd3, 1'b1, 32'h0, 16'h0);
        chk("lit_default_ctl", {28'd0, bus.alu_ctl}, 32'h2);
        chk("lit_default_res", bus.alu_res, 32'd6);

        // Randomized back-to-back traffic with occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            idx = $urandom_range(0, 10);
            r   = $urandom;
            x   = pick_operand();
            y   = pick_operand();
            p   = pick_operand();
            rr  = ($urandom_range(0, 24) == 0);
            apply(rr, (idx == 32'd10) ? r[5:0] : ops[idx[3:0]], x, y, r[8],
                  p, r[31:16]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
